// File: rtl/perf_pkg.sv
// Shared state encoding and default event-channel mapping for the
// performance counter bank.
package perf_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  localparam int unsigned EVT_INST  = 0;
  localparam int unsigned EVT_IHIT  = 1;
  localparam int unsigned EVT_DHIT  = 2;
  localparam int unsigned EVT_IREQ  = 3;
  localparam int unsigned EVT_DREQ  = 4;
  localparam int unsigned EVT_STALL = 5;

endpackage

// File: rtl/perf_counter_cell.sv
// One statistics counter: live count, shadow copy and sticky overflow flag.
// Next-state values are exported so the bank can snapshot and read them.
module perf_counter_cell
  import perf_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic             snap_i,
  output logic [CNT_W-1:0] cnt_nxt_o,
  output logic [CNT_W-1:0] shw_nxt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shw_q, shw_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    shw_d = shw_q;
    ovf_d = ovf_q;
    if (inc_i) begin
      if (cnt_q == '1) begin
        ovf_d = 1'b1;
        cnt_d = {CNT_W{SATURATE}};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // Shadow takes the post-increment value of the same edge.
    if (snap_i) shw_d = cnt_d;
    if (clear_i) begin
      cnt_d = '0;
      shw_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      shw_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      shw_q <= shw_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_nxt_o = cnt_d;
  assign shw_nxt_o = shw_d;
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Run-time statistics counter bank: NUM_EVT event channels plus a cycle
// counter, halt freeze, watchdog, atomic snapshot and a registered read port.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int unsigned NUM_EVT  = 6,
  parameter int unsigned CNT_W    = 32,
  parameter bit          SATURATE = 1'b1,
  parameter int unsigned TIMEOUT  = 100000,
  parameter int unsigned IDX_W    = $clog2(NUM_EVT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               clear,
  input  logic               hlt,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               snap,
  input  logic               rd_req,
  input  logic [IDX_W-1:0]   rd_idx,
  input  logic               rd_shadow,
  output logic               rd_valid,
  output logic [CNT_W-1:0]   rd_data,
  output logic [NUM_EVT:0]   ovf,
  output logic               running,
  output logic               halted,
  output logic               timeout
);

  localparam int unsigned      NUM_CNT = NUM_EVT + 1;
  // A TIMEOUT the cycle counter cannot represent would never be reached.
  localparam bit               TO_EN   = (TIMEOUT != 0) && ($clog2(TIMEOUT + 1) <= CNT_W);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic             timeout_q, timeout_d;
  logic             rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             count_en;
  logic [NUM_EVT:0] inc_vec;
  logic [CNT_W-1:0] live_nxt [NUM_CNT];
  logic [CNT_W-1:0] shw_nxt  [NUM_CNT];
  logic [CNT_W-1:0] rd_sel;

  // Counting stops on the edge the watchdog fires, one cycle before HALTED.
  assign count_en = (state_q == S_RUN) && !timeout_q && !clear;
  assign inc_vec  = {count_en, evt & {NUM_EVT{count_en}}};

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cell
    perf_counter_cell #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (clear),
      .inc_i     (inc_vec[g]),
      .snap_i    (snap),
      .cnt_nxt_o (live_nxt[g]),
      .shw_nxt_o (shw_nxt[g]),
      .ovf_o     (ovf[g])
    );
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start) state_d = S_RUN;
        S_RUN:    if (hlt || timeout_q) state_d = S_HALTED;
        S_HALTED: state_d = S_HALTED;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    timeout_d = timeout_q;
    if (clear) begin
      timeout_d = 1'b0;
    end else if (TO_EN && count_en && (live_nxt[NUM_EVT] == TO_VAL)) begin
      timeout_d = 1'b1;
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      if (rd_idx == IDX_W'(i)) rd_sel = rd_shadow ? shw_nxt[i] : live_nxt[i];
    end
    rd_valid_d = rd_req;
    rd_data_d  = rd_req ? rd_sel : rd_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timeout_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      timeout_q  <= timeout_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign running  = (state_q == S_RUN);
  assign halted   = (state_q == S_HALTED);
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench for perf_counter_bank: a 32-bit bank with a short watchdog
// plus two 4-bit banks (saturating and wrapping) driven with the same stimulus.
module tb_perf_counter_bank;

  logic       clk = 1'b0;
  logic       rst, start, clear, hlt, snap, rd_req, rd_shadow;
  logic [5:0] evt;
  logic [2:0] rd_idx;

  logic        m_rd_valid, m_running, m_halted, m_timeout;
  logic [31:0] m_rd_data;
  logic [6:0]  m_ovf;
  logic        s_rd_valid, s_running, s_halted, s_timeout;
  logic [3:0]  s_rd_data;
  logic [6:0]  s_ovf;
  logic        w_rd_valid, w_running, w_halted, w_timeout;
  logic [3:0]  w_rd_data;
  logic [6:0]  w_ovf;

  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [31:0] exp_m;
    logic [3:0]  exp_s;
    logic [3:0]  exp_w;
    bit          chk_small;
    int unsigned due;
  } rd_exp_t;

  rd_exp_t sb[$];
  string   sb_name[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  perf_counter_bank #(.NUM_EVT(6), .CNT_W(32), .SATURATE(1'b1), .TIMEOUT(50)) u_m (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .hlt(hlt), .evt(evt),
    .snap(snap), .rd_req(rd_req), .rd_idx(rd_idx), .rd_shadow(rd_shadow),
    .rd_valid(m_rd_valid), .rd_data(m_rd_data), .ovf(m_ovf),
    .running(m_running), .halted(m_halted), .timeout(m_timeout));

  perf_counter_bank #(.NUM_EVT(6), .CNT_W(4), .SATURATE(1'b1), .TIMEOUT(0)) u_s (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .hlt(hlt), .evt(evt),
    .snap(snap), .rd_req(rd_req), .rd_idx(rd_idx), .rd_shadow(rd_shadow),
    .rd_valid(s_rd_valid), .rd_data(s_rd_data), .ovf(s_ovf),
    .running(s_running), .halted(s_halted), .timeout(s_timeout));

  perf_counter_bank #(.NUM_EVT(6), .CNT_W(4), .SATURATE(1'b0), .TIMEOUT(0)) u_w (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .hlt(hlt), .evt(evt),
    .snap(snap), .rd_req(rd_req), .rd_idx(rd_idx), .rd_shadow(rd_shadow),
    .rd_valid(w_rd_valid), .rd_data(w_rd_data), .ovf(w_ovf),
    .running(w_running), .halted(w_halted), .timeout(w_timeout));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    start  = 1'b0;
    clear  = 1'b0;
    snap   = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic rd(input logic [2:0] idx, input bit shw, input logic [31:0] em,
                    input bit cs, input logic [3:0] es, input logic [3:0] ew, input string nm);
    rd_exp_t e;
    rd_req    = 1'b1;
    rd_idx    = idx;
    rd_shadow = shw;
    e.exp_m = em;
    e.exp_s = es;
    e.exp_w = ew;
    e.chk_small = cs;
    e.due = cyc + 1;
    sb.push_back(e);
    sb_name.push_back(nm);
  endtask

  initial begin : monitor
    rd_exp_t e;
    string   nm;
    forever begin
      @(negedge clk);
      if (m_rd_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_rd_valid got rd_data %0d want no response", m_rd_data);
        end else begin
          e  = sb.pop_front();
          nm = sb_name.pop_front();
          check({nm, "_latency"}, cyc, e.due);
          check(nm, m_rd_data, e.exp_m);
          if (e.chk_small) begin
            check({nm, "_sat_valid"}, 32'(s_rd_valid), 32'd1);
            check({nm, "_sat"}, 32'(s_rd_data), 32'(e.exp_s));
            check({nm, "_wrap_valid"}, 32'(w_rd_valid), 32'd1);
            check({nm, "_wrap"}, 32'(w_rd_data), 32'(e.exp_w));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL sim_timeout got no finish want finish");
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b1; start = 1'b0; clear = 1'b0; hlt = 1'b0; evt = '0;
    snap = 1'b0; rd_req = 1'b0; rd_idx = '0; rd_shadow = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_running", 32'(m_running), 0);
    check("rst_halted", 32'(m_halted), 0);
    check("rst_timeout", 32'(m_timeout), 0);
    check("rst_ovf", 32'(m_ovf), 0);
    check("rst_rd_valid", 32'(m_rd_valid), 0);
    check("rst_rd_data", m_rd_data, 0);

    // Reset/start: 10 RUN cycles of evt[0], snapshot on the 10th.
    start = 1'b1; step();
    evt = 6'b000001;
    for (int k = 1; k <= 10; k++) begin
      if (k == 10) snap = 1'b1;
      step();
    end
    evt = '0;
    check("t1_running", 32'(m_running), 1);
    rd(3'd6, 1'b1, 10, 1'b1, 4'd10, 4'd10, "t1_cyc_shw"); step();
    rd(3'd0, 1'b1, 10, 1'b1, 4'd10, 4'd10, "t1_ch0_shw"); step();
    rd(3'd1, 1'b1, 0, 1'b1, 4'd0, 4'd0, "t1_ch1_shw"); step();
    rd(3'd5, 1'b1, 0, 1'b1, 4'd0, 4'd0, "t1_ch5_shw"); step();
    clear = 1'b1; step();

    // Halt freeze: hlt on RUN cycle 5, evt[1] throughout.
    start = 1'b1; step();
    evt = 6'b000010;
    for (int k = 1; k <= 5; k++) begin
      hlt = (k == 5);
      step();
    end
    hlt = 1'b0;
    check("t2_halted", 32'(m_halted), 1);
    check("t2_not_running", 32'(m_running), 0);
    for (int k = 1; k <= 20; k++) begin
      if (k == 10) start = 1'b1;
      step();
    end
    check("t2_still_halted", 32'(m_halted), 1);
    rd(3'd1, 1'b0, 5, 1'b1, 4'd5, 4'd5, "t2_ch1"); step();
    rd(3'd6, 1'b0, 5, 1'b1, 4'd5, 4'd5, "t2_cyc"); step();
    rd(3'd0, 1'b0, 0, 1'b1, 4'd0, 4'd0, "t2_ch0"); step();
    evt = '0;
    clear = 1'b1; step();

    // Overflow: 17 events on ch2; 4-bit cycle counters also overflow.
    start = 1'b1; step();
    evt = 6'b000100;
    repeat (17) step();
    evt = '0;
    check("t3_ovf_m", 32'(m_ovf), 0);
    check("t3_ovf_sat", 32'(s_ovf), 32'b1000100);
    check("t3_ovf_wrap", 32'(w_ovf), 32'b1000100);
    rd(3'd2, 1'b0, 17, 1'b1, 4'hF, 4'd1, "t3_ch2"); step();
    clear = 1'b1; step();
    check("t3_ovf_clr", 32'(s_ovf), 0);

    // Watchdog at 50 cycles.
    start = 1'b1; step();
    repeat (49) step();
    check("t4_to_early", 32'(m_timeout), 0);
    step();
    check("t4_timeout", 32'(m_timeout), 1);
    check("t4_not_halted_yet", 32'(m_halted), 0);
    step();
    check("t4_halted", 32'(m_halted), 1);
    rd(3'd6, 1'b0, 50, 1'b0, 4'd0, 4'd0, "t4_cyc"); step();
    repeat (5) step();
    rd(3'd6, 1'b0, 50, 1'b0, 4'd0, 4'd0, "t4_cyc_frozen"); step();
    clear = 1'b1; step();
    check("t4_timeout_clr", 32'(m_timeout), 0);

    // Snapshot at cycle 8 with evt[4] every cycle, then back-to-back reads.
    start = 1'b1; step();
    evt = 6'b010000;
    for (int k = 1; k <= 10; k++) begin
      if (k == 8) snap = 1'b1;
      step();
    end
    rd(3'd6, 1'b1, 8, 1'b1, 4'd8, 4'd8, "t5_cyc_shw"); step();
    rd(3'd6, 1'b0, 12, 1'b1, 4'd12, 4'd12, "t5_cyc_live"); step();
    rd(3'd7, 1'b0, 0, 1'b1, 4'd0, 4'd0, "t5_bad_idx"); step();
    rd(3'd4, 1'b1, 8, 1'b1, 4'd8, 4'd8, "t5_ch4_shw"); step();
    rd(3'd4, 1'b0, 15, 1'b1, 4'd15, 4'd15, "t5_ch4_live"); step();
    step();

    // Asynchronous reset with a read in flight.
    rd_req = 1'b1; rd_idx = 3'd4; rd_shadow = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    rd_req = 1'b0;
    evt = '0;
    check("t6_rd_valid", 32'(m_rd_valid), 0);
    check("t6_rd_data", m_rd_data, 0);
    check("t6_running", 32'(m_running), 0);
    check("t6_ovf", 32'(m_ovf), 0);
    step();
    step();
    rst = 1'b0;
    step();
    check("t6_no_valid", 32'(m_rd_valid), 0);
    rd(3'd6, 1'b1, 0, 1'b1, 4'd0, 4'd0, "t6_cyc_shw"); step();

    // clear with snap and a read in the same cycle.
    start = 1'b1; step();
    evt = 6'b000001;
    repeat (3) step();
    snap = 1'b1; step();
    clear = 1'b1; snap = 1'b1;
    rd(3'd0, 1'b0, 0, 1'b1, 4'd0, 4'd0, "t7_rd_on_clear"); step();
    evt = '0;
    check("t7_idle_running", 32'(m_running), 0);
    check("t7_idle_halted", 32'(m_halted), 0);
    rd(3'd0, 1'b1, 0, 1'b1, 4'd0, 4'd0, "t7_ch0_shw"); step();
    rd(3'd6, 1'b1, 0, 1'b1, 4'd0, 4'd0, "t7_cyc_shw"); step();
    repeat (2) step();

    check("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Synthesizable bank of run-time statistics counters for the pipelined CPU with caches.
- Generalises the bench-side counting of retired instructions, I/D-cache hits and requests, and cycles into RTL that lives beside the cpu top level.
- Has NUM_EVT event channels, a free-running cycle counter, halt freeze, a watchdog timeout, per-channel sticky overflow flags, and an atomic snapshot.
- Provides a registered read port for debug and test access.

Parameters:
- NUM_EVT, 6, number of event channels. Default mapping: 0 inst retired, 1 ICacheHit, 2 DCacheHit, 3 ICacheReq, 4 DCacheReq, 5 stall.
- CNT_W, 32, width of every counter including the cycle counter.
- SATURATE, 1, overflow mode: 1 = counter sticks at all-ones; 0 = counter wraps to 0.
- TIMEOUT, 100000, cycle count at which the timeout output asserts. 0 disables the watchdog.
- IDX_W, $clog2(NUM_EVT+1), width of the read index. Index NUM_EVT selects the cycle counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  pulse: IDLE -> RUN.
- clear  in  1  pulse: zero all counters, flags and snapshot; go to IDLE.
- hlt  in  1  cpu halt indication.
- evt  in  NUM_EVT  per-channel event strobes; each is counted at most once per cycle.
- snap  in  1  pulse: copy all live counters into the shadow registers.
- rd_req  in  1  read request.
- rd_idx  in  IDX_W  index of the counter to read.
- rd_shadow  in  1  1 = read the shadow copy, 0 = read the live counter.
- rd_valid  out  1  read data valid.
- rd_data  out  CNT_W  read data.
- ovf  out  NUM_EVT+1  sticky overflow flags; bit NUM_EVT belongs to the cycle counter.
- running  out  1  high while in the RUN state.
- halted  out  1  high while in the HALTED state.
- timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset: rst asynchronously forces the following, regardless of state or a read in flight.
  - state = IDLE
  - all live counters and shadows = 0
  - ovf = 0, timeout = 0, rd_valid = 0, rd_data = 0
- State machine (three states):
  - IDLE -> RUN on start.
  - RUN -> HALTED on the first cycle with hlt = 1.
  - HALTED stays HALTED. start is ignored in HALTED and in RUN.
  - clear in any state -> IDLE.
- Counting:
  - Only in RUN, including the cycle on which hlt is first seen. That halt cycle is counted, then everything freezes.
  - The cycle counter increments every RUN cycle.
  - evt[i] increments channel i.
  - Counters hold in IDLE and HALTED.
- Overflow: an increment while a counter is all-ones sets ovf[i].
  - SATURATE = 1: the counter holds at all-ones.
  - SATURATE = 0: the counter wraps to 0.
  - ovf[i] clears only on clear or rst.
- Timeout:
  - Applies only when TIMEOUT != 0.
  - Set when, in RUN, the cycle counter's value after increment equals TIMEOUT.
  - Sticky; a timeout forces RUN -> HALTED on the next edge.
- Snapshot: snap copies all NUM_EVT+1 counters in the same edge.
  - Each shadow receives the post-increment value of that cycle.
  - snap is honoured in every state.
- Read port: one-cycle latency.
  - rd_req at edge N gives rd_valid = 1 and rd_data valid after edge N+1, for one cycle.
  - The value returned is the counter value after edge N's update.
  - If rd_idx > NUM_EVT: rd_data = 0 and rd_valid = 1.
  - Back-to-back requests give back-to-back responses; there is no backpressure.
- Simultaneous events, in priority order:
  - rst over everything.
  - clear over start, snap and counting. A snap in the same cycle as clear yields zero shadows.
  - A read in the same cycle as clear returns 0.
  - hlt and start together in IDLE: go to RUN only; hlt is evaluated in RUN on later cycles.

Decomposition:
- Shared package perf_pkg:
  - state encoding localparams: S_IDLE = 2'd0, S_RUN = 2'd1, S_HALTED = 2'd2
  - default channel index constants: EVT_INST, EVT_IHIT, EVT_DHIT, EVT_IREQ, EVT_DREQ, EVT_STALL
- One natural sub-module, perf_counter_cell, instantiated NUM_EVT+1 times via generate. Each cell contains:
  - the live counter
  - the shadow register
  - the sticky ovf bit
  - the saturate/wrap logic, selected by a SATURATE parameter
- The top level holds the state machine, the watchdog compare and the read mux/register.

Test Plan:
- Reset/start: rst 1 for 2 cycles; start; 10 RUN cycles with evt = 6'b000001 every cycle -> cycle counter = 10, ch0 = 10, others 0; running = 1.
- Halt freeze: hlt in RUN cycle 5 with evt[1] = 1 throughout -> ch1 = 5, cycle counter = 5, halted = 1; a further 20 cycles change nothing; a start pulse is ignored.
- Overflow: CNT_W = 4.
  - SATURATE = 1, 17 events on ch2 -> ch2 = 4'hF, ovf[2] = 1.
  - SATURATE = 0 -> ch2 = 1, ovf[2] = 1.
- Watchdog: TIMEOUT = 50, no hlt -> timeout = 1 after cycle 50; cycle counter = 50; halted = 1 on the next cycle.
- Snapshot/read: snap at cycle 8, then run 4 more cycles.
  - rd_idx = NUM_EVT, rd_shadow = 1 -> rd_data = 8 one cycle after rd_req.
  - rd_shadow = 0 -> 12.
  - rd_idx = 7 -> 0 with rd_valid = 1.
- Mid-run reset/clear: assert rst asynchronously mid-cycle with rd_req pending -> all outputs 0 immediately, rd_valid never asserts. clear + snap in the same cycle -> shadows 0, state IDLE.
